// File: rtl/period_capture_if.sv
// Buffer read / handshake bundle between the period capture stage and the averager.
// The master modport is the capture stage; the slave modport is the averager.
interface period_capture_if #(
  parameter int unsigned WIDTH = 25
);
  logic [1:0]       address_r;
  logic [WIDTH-1:0] data;
  logic             active;
  logic             avg_done;
  logic             result_valid;

  modport master (
    input  address_r,
    input  avg_done,
    output data,
    output active,
    output result_valid
  );

  modport slave (
    output address_r,
    output avg_done,
    input  data,
    input  active,
    input  result_valid
  );
endinterface

// File: rtl/period_capture.sv
// Frequency meter front end: synchronises sig_in, measures four consecutive rising-edge
// periods in clk cycles and holds them in a 4-entry buffer for the averager.
module period_capture #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  period_capture_if.master bus,
  output logic             busy,
  output logic             overflow
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArm     = 2'd1;
  localparam logic [1:0] StMeasure = 2'd2;
  localparam logic [1:0] StHold    = 2'd3;

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       wp_q, wp_d;
  logic             overflow_q, overflow_d;
  logic             result_valid_q, result_valid_d;
  logic             wr_en;
  logic             accept;
  logic [WIDTH-1:0] buf_q [4];

  assign rise = s2_q & ~s3_q;

  // A start is only honoured when no capture is running.
  assign accept = start && ((state_q == StIdle) || (state_q == StHold));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wp_d           = wp_q;
    overflow_d     = overflow_q;
    result_valid_d = result_valid_q;
    wr_en          = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StArm;
      end
      StArm: begin
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // A rise on the saturation cycle still writes; overflow only without a rise.
        if (rise) begin
          wr_en = 1'b1;
          wp_d  = wp_q + 2'd1;
          cnt_d = CntOne;
          if (wp_q == 2'd3) state_d = StHold;
        end else if (cnt_q == CntMax) begin
          overflow_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        if (start) begin
          state_d = StArm;
        end else if (bus.avg_done) begin
          result_valid_d = 1'b1;
        end
      end
    endcase

    if (accept) begin
      overflow_d     = 1'b0;
      result_valid_d = 1'b0;
      wp_d           = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= StIdle;
      cnt_q          <= '0;
      wp_q           <= 2'd0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      s1_q           <= sig_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wp_q           <= wp_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wp_q] <= cnt_q;
    end
  end

  assign bus.data         = buf_q[bus.address_r];
  assign bus.active       = (state_q == StHold);
  assign bus.result_valid = result_valid_q;
  assign busy             = (state_q == StArm) || (state_q == StMeasure);
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_period_capture.sv
// Directed bench for period_capture: full-width instance for capture behaviour and an
// 8-bit instance for counter saturation.
module tb_period_capture;

  logic clk = 1'b0;
  logic reset, sig_in, start, busy, overflow;
  logic sig8, start8, busy8, overflow8;
  int   checks   = 0;
  int   failures = 0;

  period_capture_if #(.WIDTH(25)) bus ();
  period_capture_if #(.WIDTH(8))  bus8 ();

  period_capture #(.WIDTH(25)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .overflow (overflow)
  );

  period_capture #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig8),
    .start    (start8),
    .bus      (bus8.master),
    .busy     (busy8),
    .overflow (overflow8)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_buf(input string tag, input int a, input int exp);
    logic [1:0] addr;
    addr = a[1:0];
    bus.address_r = addr;
    #1;
    check($sformatf("%s[%0d]", tag, a), 32'(bus.data), 32'(exp));
  endtask

  // One sig_in period of p cycles (rising edge at entry); optional sub-cycle glitch and
  // a start pulse during the low phase.
  task automatic period(input int p, input bit glitch, input bit pulse_start);
    sig_in = 1'b1;
    cyc(p / 2);
    sig_in = 1'b0;
    if (glitch) begin
      #2 sig_in = 1'b1;
      #2 sig_in = 1'b0;
    end
    if (pulse_start) begin
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(p - p / 2 - 1);
    end else begin
      cyc(p - p / 2);
    end
  endtask

  initial begin
    reset = 1'b1; sig_in = 1'b0; start = 1'b0; sig8 = 1'b0; start8 = 1'b0;
    bus.address_r = 2'd0; bus.avg_done = 1'b0;
    bus8.address_r = 2'd0; bus8.avg_done = 1'b0;
    cyc(2);
    reset = 1'b0;

    check("rst_active", 32'(bus.active), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_result_valid", 32'(bus.result_valid), 0);
    for (int i = 0; i < 4; i++) check_buf("rst_buf", i, 0);

    // Square wave of period 10.
    start = 1'b1; cyc(1); start = 1'b0;
    check("start_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) period(10, 1'b0, 1'b0);
    check("p10_active_early", 32'(bus.active), 0);
    check("p10_busy_mid", 32'(busy), 1);
    period(10, 1'b0, 1'b0);
    check("p10_active", 32'(bus.active), 1);
    check("p10_busy_done", 32'(busy), 0);
    for (int i = 0; i < 4; i++) check_buf("p10_buf", i, 10);

    bus.avg_done = 1'b1; cyc(1); bus.avg_done = 1'b0;
    check("avg_result_valid", 32'(bus.result_valid), 1);
    check("avg_active_held", 32'(bus.active), 1);

    start = 1'b1; cyc(1); start = 1'b0;
    check("restart_active", 32'(bus.active), 0);
    check("restart_result_valid", 32'(bus.result_valid), 0);
    check("restart_busy", 32'(busy), 1);

    // Uneven periods, with an ignored start and a sub-cycle glitch mid-capture.
    period(7, 1'b0, 1'b0);
    period(9, 1'b0, 1'b1);
    period(11, 1'b1, 1'b0);
    period(13, 1'b0, 1'b0);
    sig_in = 1'b1;
    cyc(2);
    check("uneven_active_on_rise", 32'(bus.active), 0);
    cyc(1);
    check("uneven_active_after", 32'(bus.active), 1);
    sig_in = 1'b0;
    check_buf("uneven_buf", 0, 7);
    check_buf("uneven_buf", 1, 9);
    check_buf("uneven_buf", 2, 11);
    check_buf("uneven_buf", 3, 13);

    // Restart beats a simultaneous avg_done.
    start = 1'b1; bus.avg_done = 1'b1; cyc(1); start = 1'b0; bus.avg_done = 1'b0;
    check("collide_result_valid", 32'(bus.result_valid), 0);
    check("collide_active", 32'(bus.active), 0);
    check("collide_busy", 32'(busy), 1);

    // Reset after two writes.
    for (int i = 0; i < 3; i++) period(10, 1'b0, 1'b0);
    check("pre_reset_busy", 32'(busy), 1);
    check_buf("pre_reset_buf", 1, 10);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_active", 32'(bus.active), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_result_valid", 32'(bus.result_valid), 0);
    for (int i = 0; i < 4; i++) check_buf("mid_rst_buf", i, 0);

    start = 1'b1; cyc(1); start = 1'b0;
    check("post_rst_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) period(6, 1'b0, 1'b0);
    check("p6_active", 32'(bus.active), 1);
    for (int i = 0; i < 4; i++) check_buf("p6_buf", i, 6);

    // Saturation on the 8-bit instance: one edge, then none.
    start8 = 1'b1; cyc(1); start8 = 1'b0;
    check("ovf_busy_start", 32'(busy8), 1);
    sig8 = 1'b1;
    cyc(3);
    cyc(254);
    check("ovf_not_yet", 32'(overflow8), 0);
    check("ovf_busy_at_max", 32'(busy8), 1);
    cyc(1);
    check("ovf_set", 32'(overflow8), 1);
    check("ovf_busy_idle", 32'(busy8), 0);
    check("ovf_active", 32'(bus8.active), 0);
    check("ovf_data", 32'(bus8.data), 0);
    start8 = 1'b1; cyc(1); start8 = 1'b0;
    check("ovf_cleared", 32'(overflow8), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
